// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (port 0) and the aux unit (port 1).
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_0_i,
  output logic                  req_ready_0_o,
  input  logic [DATA_WIDTH-1:0] req_a_0_i,
  input  logic [DATA_WIDTH-1:0] req_b_0_i,
  input  logic [3:0]            req_ctrl_0_i,
  output logic                  rsp_valid_0_o,
  input  logic                  rsp_ready_0_i,
  output logic [DATA_WIDTH-1:0] rsp_data_0_o,
  output logic                  rsp_zero_0_o,
  input  logic                  req_valid_1_i,
  output logic                  req_ready_1_o,
  input  logic [DATA_WIDTH-1:0] req_a_1_i,
  input  logic [DATA_WIDTH-1:0] req_b_1_i,
  input  logic [3:0]            req_ctrl_1_i,
  output logic                  rsp_valid_1_o,
  input  logic                  rsp_ready_1_i,
  output logic [DATA_WIDTH-1:0] rsp_data_1_o,
  output logic                  rsp_zero_1_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [3:0]            alu_control_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic [CNT_WIDTH-1:0]  stat_grant_0_o,
  output logic [CNT_WIDTH-1:0]  stat_grant_1_o,
  output logic [CNT_WIDTH-1:0]  stat_conflict_o
);

  localparam logic [3:0] CTRL_ZERO = 4'hA;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]            alu_ctrl_q, alu_ctrl_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_zero_q, rsp_zero_d;
  logic [DATA_WIDTH-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;

  logic       inflight0, inflight1, elig0, elig1, cand0, cand1;
  logic       grant0, grant1, capture;
  logic [3:0] sel_ctrl;

  function automatic logic [3:0] sanitize_ctrl(input logic [3:0] c);
    return (c > CTRL_ZERO) ? CTRL_ZERO : c;
  endfunction

  always_comb begin
    inflight0 = (state_q == S_BUSY) && (owner_q == 1'b0);
    inflight1 = (state_q == S_BUSY) && (owner_q == 1'b1);
    elig0     = req_valid_0_i && !inflight0 && (!rsp_valid_q[0] || rsp_ready_0_i);
    elig1     = req_valid_1_i && !inflight1 && (!rsp_valid_q[1] || rsp_ready_1_i);
    // Flush only blocks port 0; port 1 can still take the ALU in the same cycle.
    cand0     = elig0 && !flush_i;
    cand1     = elig1;
    grant0    = cand0 && (!cand1 || last_grant_q);
    grant1    = cand1 && (!cand0 || !last_grant_q);
    sel_ctrl  = grant1 ? req_ctrl_1_i : req_ctrl_0_i;
    capture   = (state_q == S_BUSY) && !((owner_q == 1'b0) && flush_i);

    state_d      = (grant0 || grant1) ? S_BUSY : S_IDLE;
    owner_d      = grant1;
    last_grant_d = (grant0 || grant1) ? grant1 : last_grant_q;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_ctrl_d   = CTRL_ZERO;
    if (grant0 || grant1) begin
      alu_a_d    = grant1 ? req_a_1_i : req_a_0_i;
      alu_b_d    = grant1 ? req_b_1_i : req_b_0_i;
      alu_ctrl_d = sanitize_ctrl(sel_ctrl);
    end

    // A capture wins over a same-cycle pop; flush empties port 0 outright.
    rsp_valid_d[0] = rsp_valid_q[0] && !rsp_ready_0_i && !flush_i;
    rsp_valid_d[1] = rsp_valid_q[1] && !rsp_ready_1_i;
    rsp_zero_d     = rsp_zero_q;
    rsp_data0_d    = rsp_data0_q;
    rsp_data1_d    = rsp_data1_q;
    if (capture && (owner_q == 1'b0)) begin
      rsp_valid_d[0] = 1'b1;
      rsp_zero_d[0]  = alu_zero_i;
      rsp_data0_d    = alu_result_i;
    end
    if (capture && (owner_q == 1'b1)) begin
      rsp_valid_d[1] = 1'b1;
      rsp_zero_d[1]  = alu_zero_i;
      rsp_data1_d    = alu_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= CTRL_ZERO;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end

  assign req_ready_0_o = grant0;
  assign req_ready_1_o = grant1;
  assign rsp_valid_0_o = rsp_valid_q[0];
  assign rsp_valid_1_o = rsp_valid_q[1];
  assign rsp_data_0_o  = rsp_data0_q;
  assign rsp_data_1_o  = rsp_data1_q;
  assign rsp_zero_0_o  = rsp_zero_q[0];
  assign rsp_zero_1_o  = rsp_zero_q[1];
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_control_o = alu_ctrl_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant0_cnt_q, grant0_cnt_d;
  logic [CNT_WIDTH-1:0] grant1_cnt_q, grant1_cnt_d;
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    grant0_cnt_d   = grant0 ? sat_inc(grant0_cnt_q) : grant0_cnt_q;
    grant1_cnt_d   = grant1 ? sat_inc(grant1_cnt_q) : grant1_cnt_q;
    conflict_cnt_d = (elig0 && elig1) ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant0_cnt_q   <= grant0_cnt_d;
      grant1_cnt_q   <= grant1_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_grant_0_o  = grant0_cnt_q;
  assign stat_grant_1_o  = grant1_cnt_q;
  assign stat_conflict_o = conflict_cnt_q;
`else
  assign stat_grant_0_o  = '0;
  assign stat_grant_1_o  = '0;
  assign stat_conflict_o = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, scoreboard, and corner-case sequences.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0_i, req_ready_0_o, rsp_valid_0_o, rsp_ready_0_i, rsp_zero_0_o;
  logic        req_valid_1_i, req_ready_1_o, rsp_valid_1_o, rsp_ready_1_i, rsp_zero_1_o;
  logic [31:0] req_a_0_i, req_b_0_i, rsp_data_0_o, req_a_1_i, req_b_1_i, rsp_data_1_o;
  logic [3:0]  req_ctrl_0_i, req_ctrl_1_i, alu_control_o;
  logic        flush_i, alu_zero_i;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i;
  logic [15:0] stat_grant_0_o, stat_grant_1_o, stat_conflict_o;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0_i(req_valid_0_i), .req_ready_0_o(req_ready_0_o),
    .req_a_0_i(req_a_0_i), .req_b_0_i(req_b_0_i), .req_ctrl_0_i(req_ctrl_0_i),
    .rsp_valid_0_o(rsp_valid_0_o), .rsp_ready_0_i(rsp_ready_0_i),
    .rsp_data_0_o(rsp_data_0_o), .rsp_zero_0_o(rsp_zero_0_o),
    .req_valid_1_i(req_valid_1_i), .req_ready_1_o(req_ready_1_o),
    .req_a_1_i(req_a_1_i), .req_b_1_i(req_b_1_i), .req_ctrl_1_i(req_ctrl_1_i),
    .rsp_valid_1_o(rsp_valid_1_o), .rsp_ready_1_i(rsp_ready_1_i),
    .rsp_data_1_o(rsp_data_1_o), .rsp_zero_1_o(rsp_zero_1_o),
    .flush_i(flush_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_control_o(alu_control_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .stat_grant_0_o(stat_grant_0_o), .stat_grant_1_o(stat_grant_1_o),
    .stat_conflict_o(stat_conflict_o)
  );

  always #5 clk = ~clk;

  // Reference RV32I ALU; unknown codes give a poison value so a missing sanitise is visible.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a << b[4:0];
      4'h3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4: return (a < b) ? 32'd1 : 32'd0;
      4'h5: return a >> b[4:0];
      4'h6: return $unsigned($signed(a) >>> b[4:0]);
      4'h7: return a | b;
      4'h8: return a ^ b;
      4'h9: return a & b;
      4'hA: return 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_result_i = ref_alu(alu_control_o, alu_a_o, alu_b_o);
  assign alu_zero_i   = (alu_result_i == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on each accepted request, pop on each accepted response.
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  function automatic logic [32:0] expect_of(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  cs;
    logic [31:0] r;
    cs = (c > 4'hA) ? 4'hA : c;
    r  = ref_alu(cs, a, b);
    return {(r == 32'd0), r};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (flush_i) q0.delete();
      if (rsp_valid_0_o && rsp_ready_0_i) begin
        if (q0.size() == 0) chk("sb0_unexpected_rsp", {31'd0, rsp_valid_0_o}, 32'd0);
        else begin
          logic [32:0] e;
          e = q0.pop_front();
          chk("sb0_data", rsp_data_0_o, e[31:0]);
          chk("sb0_zero", {31'd0, rsp_zero_0_o}, {31'd0, e[32]});
        end
      end
      if (rsp_valid_1_o && rsp_ready_1_i) begin
        if (q1.size() == 0) chk("sb1_unexpected_rsp", {31'd0, rsp_valid_1_o}, 32'd0);
        else begin
          logic [32:0] e;
          e = q1.pop_front();
          chk("sb1_data", rsp_data_1_o, e[31:0]);
          chk("sb1_zero", {31'd0, rsp_zero_1_o}, {31'd0, e[32]});
        end
      end
      if (req_valid_0_i && req_ready_0_o) q0.push_back(expect_of(req_ctrl_0_i, req_a_0_i, req_b_0_i));
      if (req_valid_1_i && req_ready_1_o) q1.push_back(expect_of(req_ctrl_1_i, req_a_1_i, req_b_1_i));
    end
  end

  typedef struct {
    bit          port;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_data;
    bit          exp_zero;
  } vec_t;

  vec_t vecs[13];

  task automatic drive_req(input bit p, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
    if (!p) begin
      req_valid_0_i = v; req_ctrl_0_i = c; req_a_0_i = a; req_b_0_i = b;
    end else begin
      req_valid_1_i = v; req_ctrl_1_i = c; req_a_1_i = a; req_b_1_i = b;
    end
  endtask

  task automatic stat_pulse(input logic v0, input logic v1, input logic exp_r0, input string name);
    tick();
    drive_req(1'b0, v0, 4'h0, 32'd1, 32'd1);
    drive_req(1'b1, v1, 4'h0, 32'd2, 32'd2);
    @(negedge clk);
    chk(name, {31'd0, req_ready_0_o}, {31'd0, exp_r0});
    tick();
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int  g1_count;
    logic prev0;

    vecs[0]  = '{1'b0, 4'h0, 32'd5,        32'd7,  4'h0, 32'd12,       1'b0};
    vecs[1]  = '{1'b1, 4'h1, 32'd9,        32'd9,  4'h1, 32'd0,        1'b1};
    vecs[2]  = '{1'b0, 4'h2, 32'd1,        32'd31, 4'h2, 32'h80000000, 1'b0};
    vecs[3]  = '{1'b1, 4'h3, 32'hFFFFFFFF, 32'd1,  4'h3, 32'd1,        1'b0};
    vecs[4]  = '{1'b0, 4'h4, 32'hFFFFFFFF, 32'd1,  4'h4, 32'd0,        1'b1};
    vecs[5]  = '{1'b1, 4'h5, 32'h80000000, 32'd4,  4'h5, 32'h08000000, 1'b0};
    vecs[6]  = '{1'b0, 4'h6, 32'h80000000, 32'd4,  4'h6, 32'hF8000000, 1'b0};
    vecs[7]  = '{1'b1, 4'h7, 32'hF0,       32'h0F, 4'h7, 32'hFF,       1'b0};
    vecs[8]  = '{1'b0, 4'h8, 32'hFF,       32'h0F, 4'h8, 32'hF0,       1'b0};
    vecs[9]  = '{1'b1, 4'h9, 32'hFF,       32'h0F, 4'h9, 32'h0F,       1'b0};
    vecs[10] = '{1'b0, 4'hF, 32'h1234,     32'h5678, 4'hA, 32'd0,      1'b1};
    vecs[11] = '{1'b1, 4'hB, 32'h1234,     32'h5678, 4'hA, 32'd0,      1'b1};
    vecs[12] = '{1'b0, 4'hA, 32'h1234,     32'h5678, 4'hA, 32'd0,      1'b1};

    rst_n = 1'b0;
    flush_i = 1'b0;
    rsp_ready_0_i = 1'b1;
    rsp_ready_1_i = 1'b1;
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready_1_o, req_ready_0_o}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_1_o, rsp_valid_0_o}, 32'd0);
    chk("rst_rsp_data0", rsp_data_0_o, 32'd0);
    chk("rst_rsp_data1", rsp_data_1_o, 32'd0);
    chk("rst_rsp_zero", {30'd0, rsp_zero_1_o, rsp_zero_0_o}, 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_alu_b", alu_b_o, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_control_o}, 32'hA);
    chk("rst_stats", {stat_grant_0_o, stat_grant_1_o} | {16'd0, stat_conflict_o}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Vector table: each op through one port with exact latency checks.
    foreach (vecs[i]) begin
      tick();
      drive_req(vecs[i].port, 1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk("tv_ready", {31'd0, vecs[i].port ? req_ready_1_o : req_ready_0_o}, 32'd1);
      tick();
      drive_req(vecs[i].port, 1'b0, 4'h0, 32'd0, 32'd0);
      @(negedge clk);
      chk("tv_alu_ctrl", {28'd0, alu_control_o}, {28'd0, vecs[i].exp_ctrl});
      chk("tv_alu_a", alu_a_o, vecs[i].a);
      tick();
      @(negedge clk);
      chk("tv_rsp_valid", {31'd0, vecs[i].port ? rsp_valid_1_o : rsp_valid_0_o}, 32'd1);
      chk("tv_rsp_data", vecs[i].port ? rsp_data_1_o : rsp_data_0_o, vecs[i].exp_data);
      chk("tv_rsp_zero", {31'd0, vecs[i].port ? rsp_zero_1_o : rsp_zero_0_o}, {31'd0, vecs[i].exp_zero});
    end
    tick();

    // Both ports requesting every cycle: grants alternate and the ALU never idles.
    drive_req(1'b0, 1'b1, 4'h1, 32'd9, 32'd9);
    drive_req(1'b1, 1'b1, 4'h6, 32'h80000000, 32'd4);
    prev0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_onehot", {31'd0, req_ready_0_o ^ req_ready_1_o}, 32'd1);
      if (i > 0) begin
        chk("alt_toggle", {31'd0, req_ready_0_o}, {31'd0, ~prev0});
        chk("alt_alu_busy", {31'd0, alu_control_o != 4'hA}, 32'd1);
      end
      prev0 = req_ready_0_o;
      tick();
    end
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("alt_data0", rsp_data_0_o, 32'd0);
    chk("alt_zero0", {31'd0, rsp_zero_0_o}, 32'd1);
    chk("alt_data1", rsp_data_1_o, 32'hF8000000);

    // Port 0 response held: port 0 blocked, port 1 still served.
    tick();
    rsp_ready_0_i = 1'b0;
    drive_req(1'b0, 1'b1, 4'h0, 32'd1, 32'd2);
    @(negedge clk);
    chk("hold_first_grant", {31'd0, req_ready_0_o}, 32'd1);
    tick();
    drive_req(1'b0, 1'b1, 4'h0, 32'd100, 32'd1);
    drive_req(1'b1, 1'b1, 4'h0, 32'd10, 32'd20);
    tick();
    g1_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready0_low", {31'd0, req_ready_0_o}, 32'd0);
      chk("hold_rsp_valid0", {31'd0, rsp_valid_0_o}, 32'd1);
      chk("hold_rsp_data0", rsp_data_0_o, 32'd3);
      if (req_ready_1_o) g1_count++;
      tick();
    end
    chk("hold_port1_served", {31'd0, g1_count >= 2}, 32'd1);
    rsp_ready_0_i = 1'b1;
    drive_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("hold_release_grant0", {31'd0, req_ready_0_o}, 32'd1);
    tick();
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick(); tick(); tick();

    // Flush in the port-0 BUSY cycle while port 1 is granted.
    drive_req(1'b0, 1'b1, 4'h0, 32'd3, 32'd4);
    tick();
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b1, 4'h0, 32'd1, 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready1", {31'd0, req_ready_1_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    drive_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("flush_no_rsp0_a", {31'd0, rsp_valid_0_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("flush_no_rsp0_b", {31'd0, rsp_valid_0_o}, 32'd0);
    chk("flush_rsp1_valid", {31'd0, rsp_valid_1_o}, 32'd1);
    chk("flush_rsp1_data", rsp_data_1_o, 32'd2);
    tick();
    @(negedge clk);
    chk("flush_no_rsp0_c", {31'd0, rsp_valid_0_o}, 32'd0);

    // Ready-0 forced low while flush is held.
    tick();
    drive_req(1'b0, 1'b1, 4'h0, 32'd1, 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready0", {31'd0, req_ready_0_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();

    // Reset in the middle of an operation discards it.
    drive_req(1'b0, 1'b1, 4'h0, 32'd7, 32'd7);
    tick();
    drive_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_alu_ctrl", {28'd0, alu_control_o}, 32'hA);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid0", {31'd0, rsp_valid_0_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("midrst_rsp_valid0_late", {31'd0, rsp_valid_0_o}, 32'd0);

    // Three conflicts (winners 0,1,0) then one solo port-1 request.
    stat_pulse(1'b1, 1'b1, 1'b1, "conflict1_winner0");
    stat_pulse(1'b1, 1'b1, 1'b0, "conflict2_winner1");
    stat_pulse(1'b1, 1'b1, 1'b1, "conflict3_winner0");
    stat_pulse(1'b0, 1'b1, 1'b0, "solo1_no_grant0");
    @(negedge clk);
`ifdef ALU_ARB_STATS_EN
    chk("stat_conflict", {16'd0, stat_conflict_o}, 32'd3);
    chk("stat_grant0", {16'd0, stat_grant_0_o}, 32'd2);
    chk("stat_grant1", {16'd0, stat_grant_1_o}, 32'd2);
`else
    chk("stat_conflict", {16'd0, stat_conflict_o}, 32'd0);
    chk("stat_grant0", {16'd0, stat_grant_0_o}, 32'd0);
    chk("stat_grant1", {16'd0, stat_grant_1_o}, 32'd0);
`endif
    chk("sb_drained", q0.size() + q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
